// File: rtl/direct_mapped_cache.sv
// Read-only direct-mapped cache: 256 lines of four 32-bit words, line fill from main
// memory after a fixed latency, with saturating hit/access statistics.
module direct_mapped_cache #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned LINES       = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    input  logic [14:0]  req_addr,
    output logic         req_ready,
    input  logic         flush,
    output logic         resp_valid,
    output logic [31:0]  resp_data,
    output logic         resp_hit,
    output logic [14:0]  mem_addr,
    output logic         mem_read_enable,
    input  logic [127:0] mem_line_in,
    output logic [15:0]  hit_count,
    output logic [15:0]  access_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS,
        S_FILL,
        S_RESP
    } state_t;

    state_t           state_q;
    logic [14:0]      addr_q;
    logic [3:0]       wait_q;
    logic [LINES-1:0] valid_q;
    logic [4:0]       tag_q  [LINES];
    logic [127:0]     data_q [LINES];
    logic             resp_valid_q;
    logic             resp_hit_q;
    logic [31:0]      resp_data_q;
    logic             mem_re_q;
    logic [14:0]      mem_addr_q;
    logic [15:0]      hits_q;
    logic [15:0]      acc_q;
    logic [15:0]      hits_d;
    logic [15:0]      acc_d;

    logic [4:0]       cur_tag;
    logic [7:0]       cur_idx;
    logic [1:0]       cur_off;
    logic             lookup_hit;

    assign cur_tag    = addr_q[14:10];
    assign cur_idx    = addr_q[9:2];
    assign cur_off    = addr_q[1:0];
    assign lookup_hit = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);

    function automatic logic [31:0] word_sel(input logic [127:0] line, input logic [1:0] off);
        return line[{off, 5'd0} +: 32];
    endfunction

    // Statistics stick at all-ones instead of wrapping.
    always_comb begin
        hits_d = (hits_q == '1) ? hits_q : hits_q + 16'd1;
        acc_d  = (acc_q  == '1) ? acc_q  : acc_q  + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wait_q       <= '0;
            valid_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_data_q  <= '0;
            mem_re_q     <= 1'b0;
            mem_addr_q   <= '0;
            hits_q       <= '0;
            acc_q        <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (flush) begin
                        valid_q <= '0;
                    end else if (req_valid) begin
                        addr_q  <= req_addr;
                        acc_q   <= acc_d;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (lookup_hit) begin
                        resp_data_q  <= word_sel(data_q[cur_idx], cur_off);
                        resp_hit_q   <= 1'b1;
                        resp_valid_q <= 1'b1;
                        hits_q       <= hits_d;
                        state_q      <= S_RESP;
                    end else begin
                        mem_addr_q <= {addr_q[14:2], 2'b00};
                        mem_re_q   <= 1'b1;
                        wait_q     <= '0;
                        state_q    <= S_MISS;
                    end
                end
                S_MISS: begin
                    if (wait_q == 4'(MEM_LATENCY - 1)) begin
                        state_q <= S_FILL;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                S_FILL: begin
                    valid_q[cur_idx] <= 1'b1;
                    mem_re_q         <= 1'b0;
                    resp_data_q      <= word_sel(mem_line_in, cur_off);
                    resp_hit_q       <= 1'b0;
                    resp_valid_q     <= 1'b1;
                    state_q          <= S_RESP;
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Tag/data arrays carry no reset; the valid vector alone decides residency.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_FILL) begin
            tag_q[cur_idx]  <= cur_tag;
            data_q[cur_idx] <= mem_line_in;
        end
    end

    assign req_ready       = (state_q == S_IDLE) && !flush;
    assign resp_valid      = resp_valid_q;
    assign resp_data       = resp_data_q;
    assign resp_hit        = resp_hit_q;
    assign mem_addr        = mem_addr_q;
    assign mem_read_enable = mem_re_q;
    assign hit_count       = hits_q;
    assign access_count    = acc_q;

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Self-checking bench for direct_mapped_cache: directed scenarios plus randomized reads
// checked against a residency/counter model of the cache over a word-array memory.
module tb_direct_mapped_cache;

    localparam int unsigned LAT = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic [14:0]  req_addr = '0;
    logic         req_ready;
    logic         flush = 1'b0;
    logic         resp_valid;
    logic [31:0]  resp_data;
    logic         resp_hit;
    logic [14:0]  mem_addr;
    logic         mem_read_enable;
    logic [127:0] mem_line_in;
    logic [15:0]  hit_count;
    logic [15:0]  access_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [32768];
    bit          ref_valid [256];
    logic [4:0]  ref_tag   [256];
    int          exp_acc = 0;
    int          exp_hit = 0;

    direct_mapped_cache #(.MEM_LATENCY(LAT), .LINES(256)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .flush(flush), .resp_valid(resp_valid),
        .resp_data(resp_data), .resp_hit(resp_hit), .mem_addr(mem_addr),
        .mem_read_enable(mem_read_enable), .mem_line_in(mem_line_in),
        .hit_count(hit_count), .access_count(access_count)
    );

    always #5 clk = ~clk;

    assign mem_line_in = {mem[{mem_addr[14:2], 2'd3}], mem[{mem_addr[14:2], 2'd2}],
                          mem[{mem_addr[14:2], 2'd1}], mem[{mem_addr[14:2], 2'd0}]};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        exp_acc = 0;
        exp_hit = 0;
    endtask

    // Expected outcome of one read: hit iff the line holds this tag; data always equals memory.
    task automatic model_read(input logic [14:0] a, output logic h, output logic [31:0] d,
                              output int lat);
        int idx;
        idx = int'(a[9:2]);
        h   = ref_valid[idx] && (ref_tag[idx] == a[14:10]);
        d   = mem[a];
        lat = h ? 2 : 3 + int'(LAT);
        if (exp_acc < 65535) exp_acc++;
        if (h && exp_hit < 65535) exp_hit++;
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = a[14:10];
    endtask

    task automatic do_read(input logic [14:0] a, output logic [31:0] d, output logic h,
                           output int lat, output logic [14:0] ma, output bit one_shot);
        int w;
        w = 0;
        ma = '0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (mem_read_enable) ma = mem_addr;
            if (resp_valid) break;
        end
        if (!resp_valid) lat = -1;
        d = resp_data;
        h = resp_hit;
        @(negedge clk);
        one_shot = !resp_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_hit !== 1'b0) begin errors++; $display("FAIL rst_resp_hit got=%b exp=0", resp_hit); end
        checks++; if (resp_data !== 32'd0) begin errors++; $display("FAIL rst_resp_data got=%h exp=0", resp_data); end
        checks++; if (mem_read_enable !== 1'b0) begin errors++; $display("FAIL rst_mre got=%b exp=0", mem_read_enable); end
        checks++; if (mem_addr !== 15'd0) begin errors++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL rst_hits got=%h exp=0", hit_count); end
        checks++; if (access_count !== 16'd0) begin errors++; $display("FAIL rst_acc got=%h exp=0", access_count); end
    endtask

    task automatic test_directed();
        logic [31:0] d, ed;
        logic h, eh;
        int lat, el;
        logic [14:0] ma;
        bit os;

        do_read(15'd1030, d, h, lat, ma, os);
        model_read(15'd1030, eh, ed, el);
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL d1_hit got=%b exp=0", h); end
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL d1_data got=%h exp=1", d); end
        checks++; if (lat != 5) begin errors++; $display("FAIL d1_latency got=%0d exp=5", lat); end
        checks++; if (ma !== 15'd1028) begin errors++; $display("FAIL d1_mem_addr got=%0d exp=1028", ma); end
        checks++; if (!os) begin errors++; $display("FAIL d1_one_shot got=2cycles exp=1cycle"); end

        do_read(15'd1031, d, h, lat, ma, os);
        model_read(15'd1031, eh, ed, el);
        checks++; if (h !== 1'b1) begin errors++; $display("FAIL d2_hit got=%b exp=1", h); end
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL d2_data got=%h exp=1", d); end
        checks++; if (lat != 2) begin errors++; $display("FAIL d2_latency got=%0d exp=2", lat); end
        checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL d2_hits got=%0d exp=1", hit_count); end
        checks++; if (access_count !== 16'd2) begin errors++; $display("FAIL d2_acc got=%0d exp=2", access_count); end

        do_read(15'd2054, d, h, lat, ma, os);
        model_read(15'd2054, eh, ed, el);
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL d3_hit got=%b exp=0", h); end
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL d3_data got=%h exp=1", d); end
        checks++; if (ma !== 15'd2052) begin errors++; $display("FAIL d3_mem_addr got=%0d exp=2052", ma); end

        do_read(15'd1030, d, h, lat, ma, os);
        model_read(15'd1030, eh, ed, el);
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL d4_evicted_hit got=%b exp=0", h); end
        checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL d4_hits got=%0d exp=1", hit_count); end
        checks++; if (access_count !== 16'd4) begin errors++; $display("FAIL d4_acc got=%0d exp=4", access_count); end
    endtask

    task automatic test_flush();
        logic [31:0] d, ed;
        logic h, eh;
        int lat, el;
        logic [14:0] ma;
        bit os, seen;

        @(negedge clk);
        flush = 1'b1;
        req_valid = 1'b1;
        req_addr = 15'd1031;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fl_ready got=%b exp=0", req_ready); end
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b0;
        model_clear();
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL fl_ignored got=resp exp=none"); end
        checks++; if (access_count !== 16'(exp_acc)) begin errors++; $display("FAIL fl_acc got=%0d exp=%0d", access_count, exp_acc); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fl_idle_ready got=%b exp=1", req_ready); end

        do_read(15'd1031, d, h, lat, ma, os);
        model_read(15'd1031, eh, ed, el);
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL fl_after_hit got=%b exp=0", h); end
        checks++; if (d !== ed) begin errors++; $display("FAIL fl_after_data got=%h exp=%h", d, ed); end
    endtask

    task automatic test_random();
        logic [31:0] d, ed;
        logic h, eh;
        int lat, el;
        logic [14:0] ma, a;
        logic [4:0] t;
        bit os;

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                @(negedge clk);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                model_clear();
            end
            t = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            a = {t, 8'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            do_read(a, d, h, lat, ma, os);
            model_read(a, eh, ed, el);
            checks++; if (h !== eh) begin errors++; $display("FAIL rnd_hit addr=%h got=%b exp=%b", a, h, eh); end
            checks++; if (d !== ed) begin errors++; $display("FAIL rnd_data addr=%h got=%h exp=%h", a, d, ed); end
            checks++; if (lat != el) begin errors++; $display("FAIL rnd_latency addr=%h got=%0d exp=%0d", a, lat, el); end
            checks++; if (!os) begin errors++; $display("FAIL rnd_one_shot addr=%h got=2cycles exp=1cycle", a); end
            checks++; if (hit_count !== 16'(exp_hit)) begin errors++; $display("FAIL rnd_hits got=%0d exp=%0d", hit_count, exp_hit); end
            checks++; if (access_count !== 16'(exp_acc)) begin errors++; $display("FAIL rnd_acc got=%0d exp=%0d", access_count, exp_acc); end
            if (!eh) begin
                checks++; if (ma !== {a[14:2], 2'b00}) begin errors++; $display("FAIL rnd_mem_addr got=%h exp=%h", ma, {a[14:2], 2'b00}); end
            end
        end
    endtask

    task automatic test_reset_mid_miss();
        logic [14:0] a;
        logic [31:0] d, ed;
        logic h, eh;
        int lat, el, w;
        logic [14:0] ma;
        bit os, seen;

        a = {5'd7, 8'd200, 2'd1};
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        @(posedge clk);
        #1 req_valid = 1'b0;
        w = 0;
        while (!mem_read_enable && w < 10) begin
            @(negedge clk);
            w++;
        end
        checks++; if (mem_read_enable !== 1'b1) begin errors++; $display("FAIL mm_enter_miss got=%b exp=1", mem_read_enable); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_read_enable !== 1'b0) begin errors++; $display("FAIL mm_mre got=%b exp=0", mem_read_enable); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mm_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (access_count !== 16'd0) begin errors++; $display("FAIL mm_acc got=%0d exp=0", access_count); end
        checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL mm_hits got=%0d exp=0", hit_count); end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mm_ready got=%b exp=1", req_ready); end
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL mm_aborted_resp got=resp exp=none"); end

        do_read(a, d, h, lat, ma, os);
        model_read(a, eh, ed, el);
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL mm_reread_hit got=%b exp=0", h); end
        checks++; if (d !== ed) begin errors++; $display("FAIL mm_reread_data got=%h exp=%h", d, ed); end
    endtask

    task automatic test_saturation();
        logic [31:0] d, ed;
        logic h, eh;
        int lat, el;
        logic [14:0] ma;
        bit os;

        @(negedge clk);
        force dut.acc_q = 16'hFFFE;
        force dut.hits_q = 16'hFFFE;
        #1;
        release dut.acc_q;
        release dut.hits_q;
        exp_acc = 65534;
        exp_hit = 65534;
        checks++; if (access_count !== 16'hFFFE) begin errors++; $display("FAIL sat_preload got=%h exp=fffe", access_count); end
        for (int k = 0; k < 3; k++) begin
            do_read(15'd3000, d, h, lat, ma, os);
            model_read(15'd3000, eh, ed, el);
            checks++; if (h !== eh) begin errors++; $display("FAIL sat_hit%0d got=%b exp=%b", k, h, eh); end
            checks++; if (access_count !== 16'(exp_acc)) begin errors++; $display("FAIL sat_acc%0d got=%h exp=%h", k, access_count, exp_acc); end
            checks++; if (hit_count !== 16'(exp_hit)) begin errors++; $display("FAIL sat_hits%0d got=%h exp=%h", k, hit_count, exp_hit); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem[i] = (i >= 1024 && i <= 8192) ? 32'd1 : $urandom;
        end
        model_reset();
        test_reset();
        test_directed();
        test_flush();
        test_random();
        test_reset_mid_miss();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/direct_mapped_cache.md
DIRECT_MAPPED_CACHE -- requirements
Module: direct_mapped_cache

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2: cycles the line read holds mem_addr/mem_read_enable before capturing mem_line_in; legal range 1..15.
REQ-002 SHALL have parameter LINES, default 256: number of cache lines, 4 x 32-bit words each; fixed at 256 (8-bit index).
REQ-003 SHALL provide clk  input  1  single clock, all state updates on its rising edge.
REQ-004 SHALL provide rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL provide req_valid  input  1  CPU read request present.
REQ-006 SHALL provide req_addr  input  15  CPU word address.
REQ-007 SHALL provide req_ready  output  1  block accepts a request this cycle.
REQ-008 SHALL provide flush  input  1  invalidate all lines.
REQ-009 SHALL provide resp_valid  output  1  one-cycle response strobe.
REQ-010 SHALL provide resp_data  output  32  returned word.
REQ-011 SHALL provide resp_hit  output  1  response came from a hit.
REQ-012 SHALL provide mem_addr  output  15  line-fill word address to main memory.
REQ-013 SHALL provide mem_read_enable  output  1  line fill in progress.
REQ-014 SHALL provide mem_line_in  input  128  line from main memory; word base+i in bits [32i+31:32i].
REQ-015 SHALL provide hit_count  output  16  saturating hit counter.
REQ-016 SHALL provide access_count  output  16  saturating accepted-request counter.

Function
REQ-017 SHALL split the address into tag = addr[14:10], index = addr[9:2], offset = addr[1:0]; each line holds a valid bit, 5-bit tag and 128-bit data.
REQ-018 SHALL implement states IDLE, LOOKUP, MISS, FILL, RESP; req_ready = 1 only in IDLE with flush = 0.
REQ-019 SHALL, in IDLE with flush = 1, clear all valid bits at that edge, ignore req_valid, and remain in IDLE; flush outside IDLE SHALL be ignored.
REQ-020 SHALL, in IDLE with req_valid = 1 and flush = 0, latch req_addr, increment access_count, and go to LOOKUP.
REQ-021 SHALL, in LOOKUP, on valid[index] and tag match, load resp_data with the offset-selected word, set resp_hit = 1, increment hit_count, and go to RESP.
REQ-022 SHALL, in LOOKUP on miss, drive mem_addr = {latched addr[14:2], 2'b00}, assert mem_read_enable, clear the wait counter, and go to MISS.
REQ-023 SHALL hold mem_addr and mem_read_enable constant for exactly MEM_LATENCY cycles in MISS, then go to FILL.
REQ-024 SHALL, in FILL, write mem_line_in, tag and valid = 1 into the indexed line (evicting any previous contents), deassert mem_read_enable, load resp_data with the offset-selected word of mem_line_in, set resp_hit = 0, and go to RESP.
REQ-025 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; resp_data/resp_hit SHALL hold until the next response.
REQ-026 SHALL give latency, from the accepting edge to the first resp_valid cycle: hit = 2 cycles, miss = 3 + MEM_LATENCY cycles.
REQ-027 SHALL saturate hit_count and access_count at 16'hFFFF, with no wrap-around.
REQ-028 SHALL, when the line is not written back, leave main memory unmodified; the block is read-only.

Reset
REQ-029 SHALL, on rst = 1 at a clock edge, from any state including mid-fill, go to IDLE and clear all valid bits, resp_valid, resp_hit, resp_data, mem_read_enable, mem_addr, hit_count and access_count to 0; no response SHALL be produced for an aborted request.
REQ-030 SHALL drive req_ready = 1 in the first cycle after rst deasserts.

Verification
REQ-031 SHALL be verified: after rst, read 15'd1030 (memory preset to 1 for 1024..8192) -> miss, resp_data = 32'd1, resp_hit = 0, mem_addr = 15'd1028, resp_valid 5 cycles after acceptance.
REQ-032 SHALL be verified: then read 15'd1031 -> hit, resp_data = 32'd1, resp_hit = 1, latency 2, hit_count = 1, access_count = 2.
REQ-033 SHALL be verified: read 15'd2054 (same index 1, tag 2) -> miss; re-read 15'd1030 -> miss (evicted), hit_count unchanged.
REQ-034 SHALL be verified: assert flush with req_valid in IDLE -> req_ready = 0, request ignored; next read of a previously cached address -> resp_hit = 0.
REQ-035 SHALL be verified: rst asserted during MISS -> mem_read_enable = 0 next cycle, no resp_valid, counters = 0, req_ready = 1 after release.
REQ-036 SHALL be verified: force access_count to 16'hFFFF via 65535 accesses, then one more -> value remains 16'hFFFF.
